// File: rtl/regbank_16x16b_wr_pkg.sv
// rtl/regbank_16x16b_wr_pkg.sv - shared widths, FSM encoding and select decoder for the write bank
package regbank_16x16b_wr_pkg;

  localparam int REG_W = 16;
  localparam int NREGS = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  function automatic logic [NREGS-1:0] decode_sel(input logic [SEL_W-1:0] idx);
    logic [NREGS-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regbank_16x16b_wr_reg.sv
// rtl/regbank_16x16b_wr_reg.sv - one storage register: load enable, sync data, async active-low clear
module regbank_16x16b_wr_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regbank_16x16b_wr.sv
// rtl/regbank_16x16b_wr.sv - 16x16b register bank write side: 1:16 demux, valid/ready write, 16-cycle clear
module regbank_16x16b_wr
  import regbank_16x16b_wr_pkg::*;
#(
  parameter int WIDTH = REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             sel3,
  input  logic             sel2,
  input  logic             sel1,
  input  logic             sel0,
  input  logic             WR_VALID,
  output logic             WR_READY,
  output logic             WR_ACK,
  input  logic             CLR_REQ,
  output logic             BUSY,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] E,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] H,
  output logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] L,
  output logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Dq
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel, wr_idx;
  logic             ack_q, clearing, accept;
  logic [NREGS-1:0] wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] q [NREGS];

  assign sel      = {sel3, sel2, sel1, sel0};
  assign clearing = (state_q == ST_CLEAR);
  assign WR_READY = (state_q == ST_IDLE);
  assign BUSY     = clearing;
  assign WR_ACK   = ack_q;
  assign accept   = WR_VALID & WR_READY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (CLR_REQ) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'hF) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= accept;
    end
  end

  // The clear sweep borrows the write port: counter replaces sel, zero replaces D.
  assign wr_idx  = clearing ? cnt_q : sel;
  assign wr_en   = (accept | clearing) ? decode_sel(wr_idx) : '0;
  assign wr_data = clearing ? '0 : D;

  for (genvar g = 0; g < NREGS; g++) begin : r
    regbank_16x16b_wr_reg #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wr_en[g]),
      .d     (wr_data),
      .q     (q[g])
    );
  end

  assign A  = q[0];
  assign B  = q[1];
  assign C  = q[2];
  assign Dq = q[3];
  assign E  = q[4];
  assign F  = q[5];
  assign G  = q[6];
  assign H  = q[7];
  assign I  = q[8];
  assign J  = q[9];
  assign K  = q[10];
  assign L  = q[11];
  assign M  = q[12];
  assign N  = q[13];
  assign O  = q[14];
  assign P  = q[15];

endmodule
